// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and width helper for the key debouncer
// Contents: per-key FSM state type and a counter-width helper.
package key_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_HELD         = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int width_for(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/key_debounce_fsm.sv
// rtl/key_debounce_fsm.sv - one key: synchronizer, debounce FSM, optional auto-repeat
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   tick          shared sample strobe; the FSM only advances on tick cycles
//   key_n         raw active-low key
//   level         debounced level, 1 = pressed
//   press         one-clk strobe on accepted press (and on repeats)
//   key_release   one-clk strobe on accepted release ('release' is a reserved word)
// Optional feature: KEY_REPEAT_EN adds the per-key auto-repeat counter.
module key_debounce_fsm
    import key_pkg::*;
#(
    parameter int STABLE_TICKS = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic key_n,
    output logic level,
    output logic press,
    output logic key_release
);

    localparam int CW = width_for(STABLE_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(STABLE_TICKS);

    if (STABLE_TICKS < 1 || STABLE_TICKS > 255 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
        $error("key_debounce_fsm: illegal parameter value");
    end

    logic       sync1_q, sync2_q;
    logic       sample;
    key_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic       level_q, level_d;
    logic       press_q, press_d;
    logic       release_q, release_d;
    logic       rep_fire;

    assign sample = ~sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= key_n;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (sample) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_PRESS_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!sample) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_HELD: begin
                    if (!sample) begin
                        if (STABLE_TICKS == 1) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_RELEASE_WAIT;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (sample) begin
                        state_d = ST_HELD;
                        cnt_d   = '0;
                    end else if (cnt_q >= CNT_LAST) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = width_for(REP_MAX + 1);

    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic          rep_first_q, rep_first_d;
    logic [RW-1:0] rep_limit;

    // Counts HELD ticks; the first period is REPEAT_DELAY, later ones REPEAT_RATE.
    // Reloading to 1 on a fire makes the fire tick itself the first of the next period.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
        rep_fire    = 1'b0;
        rep_limit   = rep_first_q ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
        if (state_q != ST_HELD) begin
            rep_cnt_d   = '0;
            rep_first_d = 1'b1;
        end else if (tick && sample) begin
            if (rep_cnt_q == rep_limit) begin
                rep_fire    = 1'b1;
                rep_cnt_d   = RW'(1);
                rep_first_d = 1'b0;
            end else begin
                rep_cnt_d = rep_cnt_q + RW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Strobes derive from the registered level's edges, so press and release
    // for one key are mutually exclusive by construction.
    always_comb begin
        level_d   = (state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT);
        press_d   = (level_d && !level_q) || rep_fire;
        release_d = !level_d && level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign level       = level_q;
    assign press       = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - multi-key debouncer top: shared tick prescaler plus per-key FSMs
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   key_n         raw active-low keys
//   key_level     debounced levels, 1 = pressed
//   press         one-clk strobes on accepted press (and repeats)
//   key_release   one-clk strobes on accepted release ('release' is a reserved word)
// Optional feature: KEY_REPEAT_EN enables auto-repeat inside each key FSM.
module key_debounce
    import key_pkg::*;
#(
    parameter int NUM_KEYS     = 3,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10,
    parameter int REPEAT_DELAY = 500,
    parameter int REPEAT_RATE  = 100
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] press,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam int PW = width_for(TICK_DIV);
    localparam logic [PW-1:0] DIV_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] div_q, div_d;
    logic          tick;

    // With TICK_DIV = 1 the count sits at 0 == DIV_LAST, so tick stays high.
    assign tick = (div_q == DIV_LAST);

    always_comb begin
        div_d = tick ? '0 : div_q + PW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce_fsm #(
            .STABLE_TICKS (STABLE_TICKS),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_fsm (
            .clk         (clk),
            .rst_n       (rst_n),
            .tick        (tick),
            .key_n       (key_n[i]),
            .level       (key_level[i]),
            .press       (press[i]),
            .key_release (key_release[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - scoreboard bench for key_debounce (TICK_DIV=1, STABLE_TICKS=4)
module tb_key_debounce;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] key_n;
    logic [2:0] key_level;
    logic [2:0] press;
    logic [2:0] key_release;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int t0;

    typedef struct {
        int         at;
        logic [2:0] p;
        logic [2:0] r;
        logic [2:0] l;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_e;

    key_debounce #(
        .NUM_KEYS     (3),
        .TICK_DIV     (1),
        .STABLE_TICKS (4),
        .REPEAT_DELAY (8),
        .REPEAT_RATE  (3)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .press       (press),
        .key_release (key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe cycle must match the next scoreboard entry.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (press != 3'b000 || key_release != 3'b000)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe cyc=%0d press=%b release=%b level=%b required=no strobe",
                         cyc, press, key_release, key_level);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.at != cyc || mon_e.p !== press || mon_e.r !== key_release || mon_e.l !== key_level) begin
                    errors++;
                    $display("FAIL strobe actual cyc=%0d press=%b release=%b level=%b required cyc=%0d press=%b release=%b level=%b",
                             cyc, press, key_release, key_level, mon_e.at, mon_e.p, mon_e.r, mon_e.l);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int at, input logic [2:0] p, input logic [2:0] r, input logic [2:0] l);
        ev_t e;
        e.at = at;
        e.p  = p;
        e.r  = r;
        e.l  = l;
        exp_q.push_back(e);
    endtask

    task automatic chk_zero(input string name);
        checks++;
        if (key_level !== 3'b000 || press !== 3'b000 || key_release !== 3'b000) begin
            errors++;
            $display("FAIL %s level=%b press=%b release=%b required all 000",
                     name, key_level, press, key_release);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = 3'b000;
        step(3);
        chk_zero("reset_outputs");

        // Keys held through reset: one press each after the full debounce.
        rst_n = 1'b1;
        push(cyc + 7, 3'b111, 3'b000, 3'b111);
        step(12);
        key_n = 3'b111;
        push(cyc + 7, 3'b000, 3'b111, 3'b000);
        step(12);

        // Clean press/release on key0.
        key_n = 3'b110;
        push(cyc + 7, 3'b001, 3'b000, 3'b001);
        step(20);
        key_n = 3'b111;
        push(cyc + 7, 3'b000, 3'b001, 3'b000);
        step(12);

        // Bouncing key1: 0,1,0,1 every 2 cycles, then hold low.
        key_n = 3'b101; step(2);
        key_n = 3'b111; step(2);
        key_n = 3'b101; step(2);
        key_n = 3'b111; step(2);
        key_n = 3'b101;
        push(cyc + 7, 3'b010, 3'b000, 3'b010);
        step(20);
        key_n = 3'b111;
        push(cyc + 7, 3'b000, 3'b010, 3'b000);
        step(12);

        // Simultaneous press, release of key2 alone, then the rest.
        key_n = 3'b000;
        push(cyc + 7, 3'b111, 3'b000, 3'b111);
        step(12);
        key_n = 3'b100;
        push(cyc + 7, 3'b000, 3'b100, 3'b011);
        step(12);
        key_n = 3'b111;
        push(cyc + 7, 3'b000, 3'b011, 3'b000);
        step(12);

        // Reset pulse while key0 is in PRESS_WAIT with cnt = 2.
        key_n = 3'b110;
        step(4);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_reset_outputs");
        step(1);
        rst_n = 1'b1;
        push(cyc + 7, 3'b001, 3'b000, 3'b001);
        step(20);
        key_n = 3'b111;
        push(cyc + 7, 3'b000, 3'b001, 3'b000);
        step(12);

        // Long hold on key0 (30 cycles).
        key_n = 3'b110;
        t0 = cyc;
        push(t0 + 7, 3'b001, 3'b000, 3'b001);
`ifdef KEY_REPEAT_EN
        for (int k = 15; k <= 30; k += 3) begin
            push(t0 + k, 3'b001, 3'b000, 3'b001);
        end
`endif
        step(30);
        key_n = 3'b111;
        push(cyc + 7, 3'b000, 3'b001, 3'b000);
        step(20);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events actual=%0d required=0 (next expected at cyc %0d)",
                     exp_q.size(), exp_q[0].at);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
